mic_capture_buffer: RTL



---
 rtl/mic_capture_buffer_if.sv | 33 +++
 rtl/mic_capture_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mic_capture_buffer_if.sv
// Buffer-side bundle between the ADC front end, the capture buffer and the correlator.
// The capture buffer takes the slave view; the driver of samples/addresses takes the master view.
interface mic_capture_buffer_if;
   logic               arm;
   logic               sample_valid;
   logic signed [15:0] sample_1;
   logic signed [15:0] sample_2;
   logic signed [15:0] sample_3;
   logic [7:0]         buffer_offset;
   logic [7:0]         buffer_offset_other;
   logic               corr_done;
   logic signed [15:0] buffer_data_1;
   logic signed [15:0] buffer_data_2;
   logic signed [15:0] buffer_data_3;
   logic               trigger;
   logic               busy;
   logic               ready;
   logic               overrun;

   modport master (
      output arm, sample_valid, sample_1, sample_2, sample_3,
      output buffer_offset, buffer_offset_other, corr_done,
      input  buffer_data_1, buffer_data_2, buffer_data_3,
      input  trigger, busy, ready, overrun
   );

   modport slave (
      input  arm, sample_valid, sample_1, sample_2, sample_3,
      input  buffer_offset, buffer_offset_other, corr_done,
      output buffer_data_1, buffer_data_2, buffer_data_3,
      output trigger, busy, ready, overrun
   );
endinterface

// File: rtl/mic_capture_buffer.sv
// Three-channel capture memory serving the correlator with a 1-in-2 trigger strobe.
// Optional macro LEVEL_TRIGGER_EN: capture starts on the first sample_1 whose magnitude exceeds THRESHOLD.
module mic_capture_buffer #(
   parameter int WINDOW_WIDTH  = 150,
   parameter int MAX_DEVIATION = 30,
   parameter int CAPTURE_LEN   = WINDOW_WIDTH + 2 * MAX_DEVIATION + 1
`ifdef LEVEL_TRIGGER_EN
   ,
   parameter logic signed [15:0] THRESHOLD = 16'sd2000
`endif
) (
   input logic                 clk,
   input logic                 reset,
   mic_capture_buffer_if.slave bus
);

   localparam logic [7:0] LAST_ADDR = 8'(CAPTURE_LEN - 1);
   localparam logic [8:0] LEN_ADDR  = 9'(CAPTURE_LEN);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      CAPTURE    = 3'd1,
      SERVE_RD   = 3'd2,
      SERVE_TRG  = 3'd3,
      DONE       = 3'd4,
      WAIT_LEVEL = 3'd5
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [7:0]         wr_ptr_r;
   logic [7:0]         wr_ptr_next_s;
   logic               wr_en_s;
   logic               overrun_r;
   logic               overrun_next_s;
   logic               level_hit_s;
   logic               trigger_r;
   logic               busy_r;
   logic               ready_r;
   logic signed [15:0] data_1_r;
   logic signed [15:0] data_2_r;
   logic signed [15:0] data_3_r;

   logic signed [15:0] mem_1 [CAPTURE_LEN];
   logic signed [15:0] mem_2 [CAPTURE_LEN];
   logic signed [15:0] mem_3 [CAPTURE_LEN];

`ifdef LEVEL_TRIGGER_EN
   localparam state_t ARM_STATE = WAIT_LEVEL;

   // 17-bit magnitude so that -32768 maps to 32768 rather than wrapping
   function automatic logic [16:0] magnitude(input logic signed [15:0] value);
      logic [16:0] ext;
      ext = {value[15], value};
      if (value[15]) begin
         magnitude = 17'd0 - ext;
      end else begin
         magnitude = ext;
      end
   endfunction

   assign level_hit_s = magnitude(bus.sample_1) > {1'b0, THRESHOLD};
`else
   localparam state_t ARM_STATE = CAPTURE;

   assign level_hit_s = 1'b0;
`endif

   // Next-state, write-enable and overrun decisions
   always_comb begin
      state_next_s   = state_r;
      wr_ptr_next_s  = wr_ptr_r;
      wr_en_s        = 1'b0;
      overrun_next_s = overrun_r;
      case (state_r)
         IDLE, DONE: begin
            if (bus.arm) begin
               state_next_s   = ARM_STATE;
               wr_ptr_next_s  = 8'd0;
               overrun_next_s = 1'b0;
            end else begin
               state_next_s = state_r;
            end
         end
         WAIT_LEVEL: begin
            if (bus.sample_valid && level_hit_s) begin
               wr_en_s       = 1'b1;
               wr_ptr_next_s = 8'd1;
               state_next_s  = CAPTURE;
            end else begin
               state_next_s = WAIT_LEVEL;
            end
         end
         CAPTURE: begin
            if (bus.sample_valid) begin
               wr_en_s       = 1'b1;
               wr_ptr_next_s = wr_ptr_r + 8'd1;
               if (wr_ptr_r == LAST_ADDR) begin
                  state_next_s = SERVE_RD;
               end else begin
                  state_next_s = CAPTURE;
               end
            end else begin
               state_next_s = CAPTURE;
            end
         end
         SERVE_RD, SERVE_TRG: begin
            if (bus.sample_valid) begin
               overrun_next_s = 1'b1;
            end else begin
               overrun_next_s = overrun_r;
            end
            if (bus.corr_done) begin
               state_next_s = DONE;
            end else if (state_r == SERVE_RD) begin
               state_next_s = SERVE_TRG;
            end else begin
               state_next_s = SERVE_RD;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, pointer and status flags; status outputs are registered from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         wr_ptr_r  <= 8'd0;
         overrun_r <= 1'b0;
         trigger_r <= 1'b0;
         busy_r    <= 1'b0;
         ready_r   <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         wr_ptr_r  <= wr_ptr_next_s;
         overrun_r <= overrun_next_s;
         trigger_r <= (state_next_s == SERVE_TRG);
         busy_r    <= (state_next_s == CAPTURE) || (state_next_s == SERVE_RD) ||
                      (state_next_s == SERVE_TRG) || (state_next_s == WAIT_LEVEL);
         ready_r   <= (state_next_s == DONE);
      end
   end

   // Sample memories carry no reset so a capture survives reset for inspection
   always_ff @(posedge clk) begin
      if (wr_en_s && !reset) begin
         mem_1[wr_ptr_r] <= bus.sample_1;
         mem_2[wr_ptr_r] <= bus.sample_2;
         mem_3[wr_ptr_r] <= bus.sample_3;
      end
   end

   // Read data is captured in SERVE_RD and held through the following trigger cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         data_1_r <= 16'sd0;
         data_2_r <= 16'sd0;
         data_3_r <= 16'sd0;
      end else if (state_r == SERVE_RD) begin
         data_1_r <= ({1'b0, bus.buffer_offset} < LEN_ADDR) ? mem_1[bus.buffer_offset] : 16'sd0;
         data_2_r <= ({1'b0, bus.buffer_offset_other} < LEN_ADDR) ? mem_2[bus.buffer_offset_other] : 16'sd0;
         data_3_r <= ({1'b0, bus.buffer_offset_other} < LEN_ADDR) ? mem_3[bus.buffer_offset_other] : 16'sd0;
      end
   end

   assign bus.buffer_data_1 = data_1_r;
   assign bus.buffer_data_2 = data_2_r;
   assign bus.buffer_data_3 = data_3_r;
   assign bus.trigger       = trigger_r;
   assign bus.busy          = busy_r;
   assign bus.ready         = ready_r;
   assign bus.overrun       = overrun_r;

endmodule
